// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready flow control,
// an optional 2-entry skid buffer, bubble masking and flush drop counting.
module pipe_stage_skid #(
    parameter int                 DATA_W    = 256,
    parameter int                 CTRL_W    = 8,
    parameter logic [CTRL_W-1:0]  KILL_MASK = CTRL_W'(8'h0F),
    parameter bit                 SKID      = 1'b1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic [CTRL_W-1:0]  m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0]  s_data_q, s_data_d;
    logic [CTRL_W-1:0]  s_ctrl_q, s_ctrl_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic               accept;
    logic               take;
    logic [CTRL_W-1:0]  in_ctrl_m;
    logic [2:0]         drop_inc;
    logic [CNT_W:0]     drop_sum;

    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign out_data  = m_data_q;
    assign out_ctrl  = m_ctrl_q & ~(KILL_MASK & {CTRL_W{~out_valid}});
    assign drop_cnt  = drop_q;

    // Skid mode derives in_ready from state only, so no path from out_ready.
    generate
        if (SKID) begin : g_skid
            assign in_ready = (state_q != TWO);
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign in_ctrl_m = in_ctrl & ~(KILL_MASK & {CTRL_W{bubble}});

    // A beat delivered downstream in the flush cycle is not a drop.
    assign drop_inc = {1'b0, occupancy} + {2'b00, accept} - {2'b00, take};
    assign drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(drop_inc);

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        drop_d   = drop_q;

        if (flush) begin
            state_d = EMPTY;
            drop_d  = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d  = ONE;
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl_m;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl_m;
                    end else if (accept) begin
                        state_d  = TWO;
                        s_data_d = in_data;
                        s_ctrl_d = in_ctrl_m;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (take) begin
                        state_d  = ONE;
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                        s_data_d = '0;
                        s_ctrl_d = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            m_data_q <= '0;
            m_ctrl_q <= '0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid instance with default
// parameters and a SKID=0, CNT_W=4 instance for saturation and comb ready.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // instance A: defaults
    logic         a_in_valid = 0, a_in_ready, a_bubble = 0, a_flush = 0;
    logic         a_out_valid, a_out_ready = 0;
    logic [7:0]   a_in_ctrl = 0, a_out_ctrl;
    logic [255:0] a_in_data = 0, a_out_data;
    logic [1:0]   a_occ;
    logic [15:0]  a_drop;

    // instance B: SKID=0, CNT_W=4
    logic         b_in_valid = 0, b_in_ready, b_bubble = 0, b_flush = 0;
    logic         b_out_valid, b_out_ready = 0;
    logic [7:0]   b_in_ctrl = 0, b_out_ctrl;
    logic [15:0]  b_in_data = 0, b_out_data;
    logic [1:0]   b_occ;
    logic [3:0]   b_drop;

    pipe_stage_skid u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .bubble(a_bubble), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occ), .drop_cnt(a_drop)
    );

    pipe_stage_skid #(
        .DATA_W(16), .CTRL_W(8), .KILL_MASK(8'h0F), .SKID(1'b0), .CNT_W(4)
    ) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .bubble(b_bubble), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occ), .drop_cnt(b_drop)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_valid", 256'(a_out_valid), 256'(0));
        chk("rst_ctrl",  256'(a_out_ctrl), 256'(0));
        chk("rst_data",  a_out_data, 256'(0));
        chk("rst_occ",   256'(a_occ), 256'(0));
        chk("rst_drop",  256'(a_drop), 256'(0));
        chk("rst_ready", 256'(a_in_ready), 256'(1));
        // beats while in reset are ignored
        a_in_valid = 1; a_in_data = 256'h77;
        tick();
        chk("rst_ignore", 256'(a_out_valid), 256'(0));
        a_in_valid = 0;
        #2 rst = 0;
        tick();

        // T1 streaming
        a_out_ready = 1;
        a_in_ctrl   = 8'h11;
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1;
            a_in_data  = 256'(i);
            tick();
            chk("t1_valid", 256'(a_out_valid), 256'(1));
            chk("t1_data",  a_out_data, 256'(i));
            chk("t1_ready", 256'(a_in_ready), 256'(1));
            chk("t1_occ",   256'(a_occ), 256'(1));
        end
        a_in_valid = 0;
        tick();
        chk("t1_drain", 256'(a_out_valid), 256'(0));

        // T2 backpressure
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 256'd5;
        tick();
        a_in_data = 256'd6;
        tick();
        a_in_valid = 0;
        chk("t2_ready0", 256'(a_in_ready), 256'(0));
        chk("t2_occ2",   256'(a_occ), 256'(2));
        chk("t2_data5",  a_out_data, 256'd5);
        a_out_ready = 1;
        #1;
        chk("t2_out5", a_out_data, 256'd5);
        tick();
        chk("t2_out6",   a_out_data, 256'd6);
        chk("t2_valid6", 256'(a_out_valid), 256'(1));
        chk("t2_ready1", 256'(a_in_ready), 256'(1));
        tick();
        chk("t2_empty", 256'(a_out_valid), 256'(0));

        // T3 bubble masking
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_ctrl   = 8'hFF;
        a_in_data   = 256'hABCD;
        a_bubble    = 1;
        tick();
        a_bubble   = 0;
        a_in_valid = 0;
        chk("t3_ctrl", 256'(a_out_ctrl), 256'(8'hF0));
        chk("t3_data", a_out_data, 256'hABCD);
        a_out_ready = 1;
        tick();
        chk("t3_inval_ctrl", 256'(a_out_ctrl), 256'(8'hF0));
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 256'd7;
        tick();
        chk("t3_nobubble", 256'(a_out_ctrl), 256'(8'hFF));

        // T4 flush with two held entries
        a_in_data = 256'd8;
        tick();
        a_in_valid = 0;
        chk("t4_occ2", 256'(a_occ), 256'(2));
        a_flush = 1;
        tick();
        a_flush = 0;
        chk("t4_valid", 256'(a_out_valid), 256'(0));
        chk("t4_ctrl",  256'(a_out_ctrl), 256'(8'hF0));
        chk("t4_occ",   256'(a_occ), 256'(0));
        chk("t4_drop",  256'(a_drop), 256'(2));
        chk("t4_ready", 256'(a_in_ready), 256'(1));
        // one held plus one accepted in the flush cycle
        a_in_valid = 1;
        a_in_data  = 256'd9;
        tick();
        a_in_data = 256'd10;
        a_flush   = 1;
        tick();
        a_flush    = 0;
        a_in_valid = 0;
        chk("t4_drop4", 256'(a_drop), 256'(4));
        chk("t4_occ0",  256'(a_occ), 256'(0));
        // held beat taken during flush is delivered, not dropped
        a_in_valid = 1;
        a_in_data  = 256'd11;
        tick();
        a_in_valid  = 0;
        a_out_ready = 1;
        a_flush     = 1;
        tick();
        a_flush     = 0;
        a_out_ready = 0;
        chk("t4_take", 256'(a_drop), 256'(4));

        // T5 async reset while full
        a_in_valid = 1;
        a_in_data  = 256'd12;
        tick();
        a_in_data = 256'd13;
        tick();
        a_in_valid = 0;
        chk("t5_occ2", 256'(a_occ), 256'(2));
        #1 rst = 1;
        #1;
        chk("t5_valid", 256'(a_out_valid), 256'(0));
        chk("t5_data",  a_out_data, 256'(0));
        chk("t5_ctrl",  256'(a_out_ctrl), 256'(0));
        chk("t5_occ",   256'(a_occ), 256'(0));
        chk("t5_ready", 256'(a_in_ready), 256'(1));
        chk("t5_drop",  256'(a_drop), 256'(0));
        #1 rst = 0;
        tick();

        // T5 saturation on 4-bit counter
        b_in_valid = 1;
        b_flush    = 1;
        b_in_data  = 16'h55;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 14) chk("t5_cnt14", 256'(b_drop), 256'(4'hE));
            if (i == 15) chk("t5_cnt15", 256'(b_drop), 256'(4'hF));
        end
        b_flush    = 0;
        b_in_valid = 0;
        chk("t5_sat", 256'(b_drop), 256'(4'hF));

        // T6 SKID=0 combinational ready
        b_out_ready = 0;
        b_in_valid  = 1;
        b_in_data   = 16'h21;
        tick();
        b_in_data = 16'h22;
        #1;
        chk("t6_rdy0", 256'(b_in_ready), 256'(0));
        b_out_ready = 1;
        #1;
        chk("t6_rdy1", 256'(b_in_ready), 256'(1));
        chk("t6_d21",  256'(b_out_data), 256'(16'h21));
        tick();
        chk("t6_d22", 256'(b_out_data), 256'(16'h22));
        b_out_ready = 0;
        b_in_data   = 16'h23;
        #1;
        chk("t6_rdy0b", 256'(b_in_ready), 256'(0));
        tick();
        chk("t6_hold22", 256'(b_out_data), 256'(16'h22));
        chk("t6_occ1",   256'(b_occ), 256'(1));
        b_out_ready = 1;
        tick();
        b_in_valid = 0;
        chk("t6_d23", 256'(b_out_data), 256'(16'h23));
        chk("t6_v23", 256'(b_out_valid), 256'(1));
        tick();
        chk("t6_empty", 256'(b_out_valid), 256'(0));
        chk("t6_drop",  256'(b_drop), 256'(4'hF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
